// File: rtl/stereo_disparity_engine.sv
// Block-matching stereo disparity core: for each left window it scans candidate
// disparities, keeps the lowest SAD/SSD cost and writes the winner (or INVALID).
module stereo_disparity_engine #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int BLOCK     = 6,
    parameter int MAX_DISP  = 64,
    parameter int PIX_W     = 8,
    parameter int COST_MODE = 1,
    localparam int ADDR_W   = $clog2(IMG_W * IMG_H),
    localparam int DISP_W   = $clog2(MAX_DISP) + 1,
    localparam longint unsigned PIX_MAX = (64'd1 << PIX_W) - 64'd1,
    localparam int COST_W   = $clog2(64'(BLOCK * BLOCK) *
                              ((COST_MODE != 0) ? PIX_MAX * PIX_MAX : PIX_MAX)) + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [COST_W-1:0] thresh_in,
    output logic [ADDR_W-1:0] left_addr_out,
    output logic [ADDR_W-1:0] right_addr_out,
    input  logic [PIX_W-1:0]  left_pix_in,
    input  logic [PIX_W-1:0]  right_pix_in,
    output logic [ADDR_W-1:0] disp_addr_out,
    output logic [DISP_W-1:0] disp_out,
    output logic              disp_valid_out,
    output logic              busy_out,
    output logic              done_out
);

    // state   | meaning
    // IDLE    | waiting for start_in
    // ISSUE   | one left/right address pair per cycle over the window
    // DRAIN   | two cycles for the last read data to land
    // COMPARE | fold candidate cost into running minimum
    // WRITE   | emit disparity for the window
    // DONE    | end-of-frame pulse
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_DRAIN, S_COMPARE, S_WRITE, S_DONE
    } state_t;

    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);
    localparam int CNT_W  = $clog2(BLOCK * BLOCK + 1);
    localparam int COL_W  = $clog2(BLOCK + 1);
    localparam logic [DISP_W-1:0] INVALID  = '1;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - BLOCK + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK * BLOCK - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BLOCK - 1);
    localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - BLOCK);
    localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - BLOCK);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   laddr_q, laddr_d, raddr_q, raddr_d;
    logic [ADDR_W-1:0]   base_q, base_d, daddr_q, daddr_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [DISP_W-1:0]   d_q, d_d, best_q, best_d, disp_q, disp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                drain_q, drain_d;
    logic [COST_W-1:0]   acc_q, acc_d, min_q, min_d, thresh_q, thresh_d;
    logic                v1_q, v1_d, v2_q;

    logic [PIX_W-1:0]    absdiff;
    logic [2*PIX_W-1:0]  sq;
    logic [COST_W-1:0]   term;
    logic [DISP_W-1:0]   d_last;
    logic                better;
    logic [COST_W-1:0]   cmp_min;
    logic [DISP_W-1:0]   cmp_best;
    logic                last_win;
    logic [ADDR_W-1:0]   next_base;

    always_comb begin
        state_d  = state_q;
        laddr_d  = laddr_q;
        raddr_d  = raddr_q;
        base_d   = base_q;
        daddr_d  = daddr_q;
        x_d      = x_q;
        y_d      = y_q;
        d_d      = d_q;
        best_d   = best_q;
        disp_d   = disp_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        drain_d  = drain_q;
        acc_d    = acc_q;
        min_d    = min_q;
        thresh_d = thresh_q;
        v1_d     = (state_q == S_ISSUE);

        absdiff = (left_pix_in >= right_pix_in) ? left_pix_in - right_pix_in
                                                : right_pix_in - left_pix_in;
        sq      = {{PIX_W{1'b0}}, absdiff} * {{PIX_W{1'b0}}, absdiff};
        term    = (COST_MODE != 0) ? COST_W'(sq) : COST_W'(absdiff);
        if (v2_q) acc_d = acc_q + term;

        if (int'(x_q) >= MAX_DISP - 1) d_last = DISP_W'(MAX_DISP - 1);
        else                           d_last = DISP_W'(x_q);

        // Strict compare: on a tie the earlier (smaller) disparity wins.
        better    = (acc_q < min_q);
        cmp_min   = better ? acc_q : min_q;
        cmp_best  = better ? d_q : best_q;
        last_win  = (x_q == X_LAST) && (y_q == Y_LAST);
        next_base = (x_q == X_LAST) ? base_q + ADDR_W'(BLOCK) : base_q + ADDR_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d  = S_ISSUE;
                    thresh_d = thresh_in;
                    x_d      = '0;
                    y_d      = '0;
                    d_d      = '0;
                    base_d   = '0;
                    laddr_d  = '0;
                    raddr_d  = '0;
                    cnt_d    = '0;
                    col_d    = '0;
                    acc_d    = '0;
                    min_d    = '1;
                    best_d   = '0;
                end
            end
            S_ISSUE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        laddr_d = laddr_q + ROW_STEP;
                        raddr_d = raddr_q + ROW_STEP;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        laddr_d = laddr_q + ADDR_W'(1);
                        raddr_d = raddr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_COMPARE;
                else         drain_d = 1'b1;
            end
            S_COMPARE: begin
                min_d  = cmp_min;
                best_d = cmp_best;
                acc_d  = '0;
                if (d_q < d_last) begin
                    state_d = S_ISSUE;
                    d_d     = d_q + DISP_W'(1);
                    laddr_d = base_q;
                    raddr_d = base_q - ADDR_W'(d_q) - ADDR_W'(1);
                    cnt_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = S_WRITE;
                    daddr_d = base_q;
                    disp_d  = (cmp_min > thresh_q) ? INVALID : cmp_best;
                end
            end
            S_WRITE: begin
                min_d  = '1;
                best_d = '0;
                d_d    = '0;
                if (last_win) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    base_d  = next_base;
                    laddr_d = next_base;
                    raddr_d = next_base;
                    cnt_d   = '0;
                    col_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            laddr_q  <= '0;
            raddr_q  <= '0;
            base_q   <= '0;
            daddr_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            d_q      <= '0;
            best_q   <= '0;
            disp_q   <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
            drain_q  <= 1'b0;
            acc_q    <= '0;
            min_q    <= '1;
            thresh_q <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            laddr_q  <= laddr_d;
            raddr_q  <= raddr_d;
            base_q   <= base_d;
            daddr_q  <= daddr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            d_q      <= d_d;
            best_q   <= best_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            drain_q  <= drain_d;
            acc_q    <= acc_d;
            min_q    <= min_d;
            thresh_q <= thresh_d;
            v1_q     <= v1_d;
            v2_q     <= v1_q;
        end
    end

    assign left_addr_out  = laddr_q;
    assign right_addr_out = raddr_q;
    assign disp_addr_out  = daddr_q;
    assign disp_out       = disp_q;
    assign disp_valid_out = (state_q == S_WRITE);
    assign busy_out       = (state_q != S_IDLE);
    assign done_out       = (state_q == S_DONE);

endmodule

// File: tb/tb_stereo_disparity_engine.sv
// Scoreboard bench for stereo_disparity_engine: a window-level reference model
// queues expected map writes, a negedge monitor pops and compares them.
module tb_stereo_disparity_engine;
    localparam int IMG_W = 16, IMG_H = 8, BLOCK = 3, MAX_DISP = 4, PIX_W = 8, COST_MODE = 1;
    localparam int ADDR_W = 7, DISP_W = 3, COST_W = 21;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int NWIN = (IMG_W - BLOCK + 1) * (IMG_H - BLOCK + 1);
    localparam logic [COST_W-1:0] ALL1 = '1;
    localparam int INV = 7;

    typedef struct { int addr; int disp; } exp_t;

    logic              clk = 1'b0;
    logic              rst_in = 1'b1;
    logic              start_in = 1'b0;
    logic [COST_W-1:0] thresh_in = '0;
    logic [ADDR_W-1:0] left_addr_out, right_addr_out, disp_addr_out;
    logic [PIX_W-1:0]  left_pix_in = '0, right_pix_in = '0;
    logic [DISP_W-1:0] disp_out;
    logic              disp_valid_out, busy_out, done_out;

    logic [7:0] lmem [NPIX];
    logic [7:0] rmem [NPIX];
    logic [7:0] lp1 = '0, rp1 = '0;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;
    int   writes_seen = 0, sevens_seen = 0;

    stereo_disparity_engine #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK(BLOCK), .MAX_DISP(MAX_DISP),
        .PIX_W(PIX_W), .COST_MODE(COST_MODE)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .thresh_in(thresh_in),
        .left_addr_out(left_addr_out), .right_addr_out(right_addr_out),
        .left_pix_in(left_pix_in), .right_pix_in(right_pix_in),
        .disp_addr_out(disp_addr_out), .disp_out(disp_out),
        .disp_valid_out(disp_valid_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame buffers with two-cycle read latency.
    always @(posedge clk) begin
        lp1          <= lmem[left_addr_out];
        rp1          <= rmem[right_addr_out];
        left_pix_in  <= lp1;
        right_pix_in <= rp1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int window_cost(input int x, input int y, input int d);
        int c = 0;
        for (int r = 0; r < BLOCK; r++)
            for (int k = 0; k < BLOCK; k++) begin
                int df;
                df = int'(lmem[(y + r) * IMG_W + x + k]) - int'(rmem[(y + r) * IMG_W + x - d + k]);
                c += df * df;
            end
        return c;
    endfunction

    function automatic int frame_cycles();
        int t = 0;
        for (int y = 0; y <= IMG_H - BLOCK; y++)
            for (int x = 0; x <= IMG_W - BLOCK; x++)
                t += (((x < MAX_DISP - 1) ? x : MAX_DISP - 1) + 1) * (BLOCK * BLOCK + 3) + 1;
        return t;
    endfunction

    task automatic push_frame(input logic [COST_W-1:0] th);
        for (int y = 0; y <= IMG_H - BLOCK; y++)
            for (int x = 0; x <= IMG_W - BLOCK; x++) begin
                int best = 0;
                int bc = 32'h7fff_ffff;
                int nd = ((x < MAX_DISP - 1) ? x : MAX_DISP - 1);
                exp_t e;
                for (int d = 0; d <= nd; d++) begin
                    int c;
                    c = window_cost(x, y, d);
                    if (c < bc) begin bc = c; best = d; end
                end
                e.addr = y * IMG_W + x;
                e.disp = (longint'(bc) > longint'(th)) ? INV : best;
                exp_q.push_back(e);
            end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_in && disp_valid_out) begin
            writes_seen++;
            if (disp_out == 3'(INV)) sevens_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d disp %0d, expected no write",
                         disp_addr_out, disp_out);
            end else begin
                e = exp_q.pop_front();
                check("disp_addr", disp_addr_out, e.addr);
                check("disp_value", disp_out, e.disp);
            end
        end
    end

    task automatic wait_done(output int c);
        int n = 0;
        while (!done_out && n < 10000) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_left_addr"}, left_addr_out, 0);
        check({tag, "_right_addr"}, right_addr_out, 0);
        check({tag, "_disp_addr"}, disp_addr_out, 0);
        check({tag, "_disp"}, disp_out, 0);
        check({tag, "_valid"}, disp_valid_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_done"}, done_out, 0);
    endtask

    task automatic run_frame(input logic [COST_W-1:0] th);
        int start_c, done_c, w0, s0, n;
        bit busy_ok;
        push_frame(th);
        w0 = writes_seen;
        s0 = sevens_seen;
        @(negedge clk);
        start_in  = 1'b1;
        thresh_in = th;
        @(negedge clk);
        start_in  = 1'b0;
        thresh_in = '0;
        start_c   = cyc;
        busy_ok   = busy_out;
        n = 0;
        while (!done_out && n < 10000) begin
            @(negedge clk);
            n++;
            if (!busy_out) busy_ok = 1'b0;
        end
        done_c = cyc;
        // done lands frame_cycles() edges after the first ISSUE cycle
        check("done_latency", done_c - start_c, frame_cycles());
        check("busy_through_frame", busy_ok, 1);
        @(negedge clk);
        check("busy_fall", busy_out, 0);
        check("done_one_cycle", done_out, 0);
        check("write_count", writes_seen - w0, NWIN);
        check("queue_drained", exp_q.size(), 0);
        if (th == 21'd10) check("invalid_count_thr10", sevens_seen - s0, NWIN);
        if (th == ALL1)   check("invalid_count_thr_max", sevens_seen - s0, 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d1, d2, w0;
        for (int i = 0; i < NPIX; i++) begin lmem[i] = '0; rmem[i] = '0; end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        repeat (2) @(negedge clk);

        // Textured left, right shifted by two columns.
        for (int i = 0; i < NPIX; i++) lmem[i] = 8'($urandom_range(0, 255));
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                rmem[y * IMG_W + x] = (x + 2 < IMG_W) ? lmem[y * IMG_W + x + 2]
                                                      : 8'($urandom_range(0, 255));
        run_frame(ALL1);

        // Identical flat images: every candidate ties at zero.
        for (int i = 0; i < NPIX; i++) begin lmem[i] = 8'h40; rmem[i] = 8'h40; end
        run_frame(ALL1);

        // Random left against a black right image, strict then disabled threshold.
        for (int i = 0; i < NPIX; i++) begin lmem[i] = 8'($urandom_range(16, 255)); rmem[i] = 8'h00; end
        run_frame(21'd10);
        run_frame(ALL1);

        // start_in held high: exactly two back-to-back frames.
        for (int i = 0; i < NPIX; i++) begin lmem[i] = 8'($urandom_range(0, 255)); rmem[i] = 8'($urandom_range(0, 255)); end
        push_frame(ALL1);
        push_frame(ALL1);
        w0 = writes_seen;
        @(negedge clk);
        start_in  = 1'b1;
        thresh_in = ALL1;
        wait_done(d1);
        @(negedge clk);
        check("held_start_idle_gap", busy_out, 0);
        @(negedge clk);
        check("held_start_restart", busy_out, 1);
        wait_done(d2);
        start_in = 1'b0;
        check("back_to_back_spacing", d2 - d1, frame_cycles() + 2);
        repeat (3) @(negedge clk);
        check("held_start_stops", busy_out, 0);
        check("held_start_writes", writes_seen - w0, 2 * NWIN);
        check("held_start_queue", exp_q.size(), 0);
        exp_q.delete();

        // Reset 500 cycles into a frame, with a start in the reset cycle.
        push_frame(ALL1);
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (499) @(negedge clk);
        check("pre_reset_busy", busy_out, 1);
        rst_in   = 1'b1;
        start_in = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_in   = 1'b0;
        start_in = 1'b0;
        exp_q.delete();
        w0 = writes_seen;
        repeat (40) @(negedge clk);
        check("no_writes_after_reset", writes_seen - w0, 0);
        check("idle_after_reset", busy_out, 0);
        run_frame(ALL1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
